// File: rtl/clk_ctrl_pkg.sv
// rtl/clk_ctrl_pkg.sv - mode/state types and State output encodings for clock_div_ctrl
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN          = 2'b00,
        STEP         = 2'b01,
        HALT         = 2'b10,
        RUN_TO_BREAK = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        LOW   = 2'd0,
        HIGH  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] STATE_ENC_LOW   = 2'd0;
    localparam logic [1:0] STATE_ENC_HIGH  = 2'd1;
    localparam logic [1:0] STATE_ENC_PAUSE = 2'd2;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer plus rising-edge detector for asynchronous inputs
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
        rise   = sync_q[STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/clock_div_ctrl.sv
// rtl/clock_div_ctrl.sv - programmable CPU clock divider with run/step/halt/breakpoint gating
import clk_ctrl_pkg::*;

module clock_div_ctrl #(
    parameter int DIV_W       = 8,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCK,
    input  logic             Reset,
    input  logic [1:0]       Mode,
    input  logic [DIV_W-1:0] HalfPeriod,
    input  logic             Step,
    input  logic [31:0]      BreakAddr,
    input  logic [31:0]      PC,
    output logic             ClockDIV,
    output logic             Halted,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] CpuCycles
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic             fresh_q, fresh_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             clk_div_q, clk_div_d;
    logic             halted_q, halted_d;

    logic             step_rise;
    logic             go;
    logic             enter_high;
    logic [DIV_W-1:0] half_eff;
    mode_t            mode;

    sync_edge #(.STAGES(SYNC_STAGES)) u_step_sync (
        .clk      (CLOCK),
        .rst      (Reset),
        .async_in (Step),
        .rise     (step_rise)
    );

    always_comb begin
        mode = mode_t'(Mode);
        go   = 1'b0;
        case (mode)
            RUN:          go = 1'b1;
            STEP:         go = pend_q;
            HALT:         go = 1'b0;
            RUN_TO_BREAK: go = (PC != BreakAddr) | pend_q;
        endcase
    end

    // The first LOW after reset has no latched length yet, so it uses the live input.
    assign half_eff = fresh_q ? HalfPeriod : half_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        fresh_d    = fresh_q;
        cyc_d      = cyc_q;
        enter_high = 1'b0;

        case (state_q)
            LOW: begin
                fresh_d = 1'b0;
                if (fresh_q) begin
                    half_d = HalfPeriod;
                end
                if (cnt_q == half_eff) begin
                    cnt_d = '0;
                    if (go) begin
                        enter_high = 1'b1;
                    end else begin
                        state_d = PAUSE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q == half_q) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    half_d  = HalfPeriod;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            PAUSE: begin
                cnt_d = '0;
                if (go) begin
                    enter_high = 1'b1;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase

        if (enter_high) begin
            state_d = HIGH;
            cnt_d   = '0;
            half_d  = HalfPeriod;
            cyc_d   = cyc_q + CNT_W'(1);
        end

        // Depth-one request: an edge coincident with HIGH entry survives as the next request.
        pend_d    = step_rise | (pend_q & ~enter_high);
        clk_div_d = (state_d == HIGH);
        halted_d  = (state_d == PAUSE);
    end

    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            state_q   <= LOW;
            cnt_q     <= '0;
            half_q    <= '0;
            fresh_q   <= 1'b1;
            pend_q    <= 1'b0;
            cyc_q     <= '0;
            clk_div_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            fresh_q   <= fresh_d;
            pend_q    <= pend_d;
            cyc_q     <= cyc_d;
            clk_div_q <= clk_div_d;
            halted_q  <= halted_d;
        end
    end

    always_comb begin
        State = STATE_ENC_LOW;
        case (state_q)
            LOW:     State = STATE_ENC_LOW;
            HIGH:    State = STATE_ENC_HIGH;
            PAUSE:   State = STATE_ENC_PAUSE;
            default: State = STATE_ENC_LOW;
        endcase
    end

    assign ClockDIV  = clk_div_q;
    assign Halted    = halted_q;
    assign CpuCycles = cyc_q;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// tb/tb_clock_div_ctrl.sv - directed, table-driven bench for clock_div_ctrl
module tb_clock_div_ctrl;

    logic        CLOCK = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  Mode = 2'b00;
    logic [7:0]  HalfPeriod = 8'd0;
    logic        Step = 1'b0;
    logic [31:0] BreakAddr = 32'hFFFF_FFFF;
    logic [31:0] PC;
    logic        ClockDIV;
    logic        Halted;
    logic [1:0]  State;
    logic [31:0] CpuCycles;

    logic [31:0] pc_m;
    int          tests = 0;
    int          fails = 0;

    clock_div_ctrl #(.DIV_W(8), .CNT_W(32), .SYNC_STAGES(2)) dut (
        .CLOCK      (CLOCK),
        .Reset      (Reset),
        .Mode       (Mode),
        .HalfPeriod (HalfPeriod),
        .Step       (Step),
        .BreakAddr  (BreakAddr),
        .PC         (PC),
        .ClockDIV   (ClockDIV),
        .Halted     (Halted),
        .State      (State),
        .CpuCycles  (CpuCycles)
    );

    always #5 CLOCK = ~CLOCK;

    // Core PC model: advances one instruction per CPU clock rise.
    always @(posedge ClockDIV or posedge Reset) begin
        if (Reset) pc_m <= 32'h0040_0000;
        else       pc_m <= pc_m + 32'd4;
    end
    assign PC = pc_m;

    typedef struct {
        logic [7:0] half;
        int         first_low;
        int         high;
        int         low;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        Reset = 1'b1;
        @(negedge CLOCK);
        Reset = 1'b0;
    endtask

    task automatic wait_level(input logic lvl, input string name);
        int n;
        n = 0;
        while (ClockDIV !== lvl && n < 2000) begin
            @(negedge CLOCK);
            n++;
        end
        check({name, " wait"}, 64'(n < 2000), 64'd1);
    endtask

    // Counts samples of the current phase; a LOW that ends in PAUSE ends the count.
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (ClockDIV === lvl && Halted === 1'b0 && n < 1000) begin
            n++;
            @(negedge CLOCK);
        end
    endtask

    initial begin
        int n, h, l, ones;

        vecs[0] = '{half: 8'd0,   first_low: 1,   high: 1,   low: 1};
        vecs[1] = '{half: 8'd3,   first_low: 4,   high: 4,   low: 4};
        vecs[2] = '{half: 8'd6,   first_low: 7,   high: 7,   low: 7};
        vecs[3] = '{half: 8'd255, first_low: 256, high: 256, low: 256};

        // Reset state
        @(negedge CLOCK);
        @(negedge CLOCK);
        check("rst ClockDIV", 64'(ClockDIV), 64'd0);
        check("rst State", 64'(State), 64'd0);
        check("rst Halted", 64'(Halted), 64'd0);
        check("rst CpuCycles", 64'(CpuCycles), 64'd0);

        // RUN phase lengths over the table
        Mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            HalfPeriod = vecs[i].half;
            do_reset();
            measure(1'b0, n);
            check($sformatf("run%0d first_low", i), 64'(n), 64'(vecs[i].first_low));
            measure(1'b1, n);
            check($sformatf("run%0d high", i), 64'(n), 64'(vecs[i].high));
            measure(1'b0, n);
            check($sformatf("run%0d low", i), 64'(n), 64'(vecs[i].low));
        end

        // Divide-by-2: 10 rises in 20 cycles
        HalfPeriod = 8'd0;
        do_reset();
        repeat (20) @(negedge CLOCK);
        check("div2 CpuCycles", 64'(CpuCycles), 64'd10);

        // HalfPeriod change mid-HIGH affects only later phases
        HalfPeriod = 8'd3;
        do_reset();
        wait_level(1'b1, "mid");
        HalfPeriod = 8'd1;
        measure(1'b1, n);
        check("mid high", 64'(n), 64'd4);
        measure(1'b0, n);
        check("mid low", 64'(n), 64'd2);
        measure(1'b1, n);
        check("mid next high", 64'(n), 64'd2);

        // STEP mode: two single periods
        Mode = 2'b01;
        HalfPeriod = 8'd2;
        do_reset();
        repeat (10) @(negedge CLOCK);
        check("step idle Halted", 64'(Halted), 64'd1);
        check("step idle CpuCycles", 64'(CpuCycles), 64'd0);
        for (int k = 0; k < 2; k++) begin
            Step = 1'b1;
            wait_level(1'b1, "step");
            Step = 1'b0;
            measure(1'b1, h);
            measure(1'b0, l);
            check($sformatf("step%0d high", k), 64'(h), 64'd3);
            check($sformatf("step%0d low", k), 64'(l), 64'd3);
            ones = 0;
            repeat (50) begin
                @(negedge CLOCK);
                if (ClockDIV) ones++;
            end
            check($sformatf("step%0d paused", k), 64'(ones), 64'd0);
            check($sformatf("step%0d Halted", k), 64'(Halted), 64'd1);
        end
        check("step CpuCycles", 64'(CpuCycles), 64'd2);

        // RUN_TO_BREAK: stop at breakpoint, step over it, resume
        Mode = 2'b11;
        HalfPeriod = 8'd1;
        BreakAddr = 32'h0040_0010;
        do_reset();
        n = 0;
        while (Halted !== 1'b1 && n < 500) begin
            @(negedge CLOCK);
            n++;
        end
        check("brk reached", 64'(n < 500), 64'd1);
        check("brk PC", 64'(pc_m), 64'h0040_0010);
        check("brk CpuCycles", 64'(CpuCycles), 64'd4);
        repeat (30) @(negedge CLOCK);
        check("brk hold CpuCycles", 64'(CpuCycles), 64'd4);
        check("brk hold State", 64'(State), 64'd2);
        Step = 1'b1;
        wait_level(1'b1, "brk step");
        Step = 1'b0;
        check("brk step PC", 64'(pc_m), 64'h0040_0014);
        wait_level(1'b0, "brk low");
        wait_level(1'b1, "brk resume");
        check("brk resume CpuCycles", 64'(CpuCycles), 64'd6);
        check("brk resume Halted", 64'(Halted), 64'd0);

        // RUN -> HALT mid-HIGH: current period completes, then stays low
        Mode = 2'b00;
        HalfPeriod = 8'd2;
        do_reset();
        wait_level(1'b1, "halt");
        Mode = 2'b10;
        measure(1'b1, h);
        measure(1'b0, l);
        check("halt high", 64'(h), 64'd3);
        check("halt low", 64'(l), 64'd3);
        check("halt Halted", 64'(Halted), 64'd1);
        ones = 0;
        repeat (100) begin
            @(negedge CLOCK);
            if (ClockDIV) ones++;
        end
        check("halt stays low", 64'(ones), 64'd0);

        // Asynchronous reset in the middle of HIGH
        Mode = 2'b00;
        HalfPeriod = 8'd5;
        do_reset();
        wait_level(1'b1, "arst");
        repeat (2) @(negedge CLOCK);
        check("arst pre ClockDIV", 64'(ClockDIV), 64'd1);
        Reset = 1'b1;
        #1;
        check("arst ClockDIV", 64'(ClockDIV), 64'd0);
        check("arst CpuCycles", 64'(CpuCycles), 64'd0);
        check("arst State", 64'(State), 64'd0);
        @(negedge CLOCK);
        Reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
